// File: rtl/se_lookup_arbiter.sv
// Round-robin arbiter that shares one search engine among N_REQ frame-processor
// requesters, each owning a single capture slot for its pending lookup.
module se_lookup_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_REQ-1:0]    rq_req,
  input  logic [48*N_REQ-1:0] rq_mac,
  input  logic [10*N_REQ-1:0] rq_hash,
  input  logic [N_REQ-1:0]    rq_source,
  input  logic [16*N_REQ-1:0] rq_portmap,
  output logic [N_REQ-1:0]    rq_ack,
  output logic [N_REQ-1:0]    rq_nak,
  output logic [15:0]         rq_result,
  output logic                se_req,
  output logic [47:0]         se_mac,
  output logic [9:0]          se_hash,
  output logic                se_source,
  output logic [15:0]         source_portmap,
  input  logic                se_ack,
  input  logic                se_nak,
  input  logic [15:0]         se_result,
  output logic [N_REQ-1:0]    pending,
  output logic [N_REQ-1:0]    ovf_err,
  output logic                to_err,
  output logic [1:0]          dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshake: rq_req is a one-cycle request pulse with no back-pressure; each
  // accepted request completes with exactly one one-cycle rq_ack or rq_nak.
  // se_req is a one-cycle pulse; the engine answers with se_ack/se_nak, which
  // are only honoured while the arbiter is waiting for that answer.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     win_q;
  logic [IW-1:0]     last_grant_q;
  logic [TW-1:0]     timer_q;

  logic              se_req_q;
  logic [47:0]       se_mac_q;
  logic [9:0]        se_hash_q;
  logic              se_source_q;
  logic [15:0]       se_portmap_q;
  logic [N_REQ-1:0]  rq_ack_q;
  logic [N_REQ-1:0]  rq_nak_q;
  logic [15:0]       rq_result_q;
  logic              to_err_q;

  logic [47:0]       slot_mac_q     [N_REQ];
  logic [9:0]        slot_hash_q    [N_REQ];
  logic              slot_source_q  [N_REQ];
  logic [15:0]       slot_portmap_q [N_REQ];
  logic [N_REQ-1:0]  pending_q;
  logic [N_REQ-1:0]  pending_d;
  logic [N_REQ-1:0]  ovf_q;

  logic [N_REQ-1:0]  release_vec;
  logic [N_REQ-1:0]  accept;
  logic [N_REQ-1:0]  drop;
  logic [N_REQ-1:0]  win_onehot;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand;

  // The slot of the current winner is freed during its RESP cycle, so a new
  // request from the same requester in that cycle is accepted cleanly.
  always_comb begin
    release_vec = '0;
    if (state_q == S_RESP) release_vec[win_q] = 1'b1;
  end

  assign accept     = rq_req & (~pending_q | release_vec);
  assign drop       = rq_req & pending_q & ~release_vec;
  assign pending_d  = (pending_q & ~release_vec) | accept;
  assign win_onehot = N_REQ'(1) << win_q;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_grant_q) + k) % N_REQ);
      if (!pick_valid && pending_q[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_mac_q[i]     <= '0;
        slot_hash_q[i]    <= '0;
        slot_source_q[i]  <= 1'b0;
        slot_portmap_q[i] <= '0;
      end
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          slot_mac_q[i]     <= rq_mac[48*i +: 48];
          slot_hash_q[i]    <= rq_hash[10*i +: 10];
          slot_source_q[i]  <= rq_source[i];
          slot_portmap_q[i] <= rq_portmap[16*i +: 16];
        end
      end
      pending_q <= pending_d;
      ovf_q     <= ovf_q | drop;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      win_q        <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      timer_q      <= '0;
      se_req_q     <= 1'b0;
      se_mac_q     <= '0;
      se_hash_q    <= '0;
      se_source_q  <= 1'b0;
      se_portmap_q <= '0;
      rq_ack_q     <= '0;
      rq_nak_q     <= '0;
      rq_result_q  <= '0;
      to_err_q     <= 1'b0;
    end else begin
      se_req_q    <= 1'b0;
      rq_ack_q    <= '0;
      rq_nak_q    <= '0;
      rq_result_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            win_q        <= pick_idx;
            se_mac_q     <= slot_mac_q[pick_idx];
            se_hash_q    <= slot_hash_q[pick_idx];
            se_source_q  <= slot_source_q[pick_idx];
            se_portmap_q <= slot_portmap_q[pick_idx];
            se_req_q     <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= TW'(1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // An ack wins over a simultaneous nak and over the final timer tick.
          if (se_ack) begin
            rq_ack_q    <= win_onehot;
            rq_result_q <= se_result;
            state_q     <= S_RESP;
          end else if (se_nak) begin
            rq_nak_q    <= win_onehot;
            rq_result_q <= se_result;
            state_q     <= S_RESP;
          end else if (timer_q == TW'(TIMEOUT)) begin
            rq_nak_q <= win_onehot;
            to_err_q <= 1'b1;
            state_q  <= S_RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP: begin
          last_grant_q <= win_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rq_ack         = rq_ack_q;
  assign rq_nak         = rq_nak_q;
  assign rq_result      = rq_result_q;
  assign se_req         = se_req_q;
  assign se_mac         = se_mac_q;
  assign se_hash        = se_hash_q;
  assign se_source      = se_source_q;
  assign source_portmap = se_portmap_q;
  assign pending        = pending_q;
  assign ovf_err        = ovf_q;
  assign to_err         = to_err_q;
  assign dbg_state      = state_q;

  a_se_req_pulse: assert property (@(posedge clk) disable iff (!rstn)
    se_req_q |=> !se_req_q);
  a_resp_pulse: assert property (@(posedge clk) disable iff (!rstn)
    (|(rq_ack_q | rq_nak_q)) |=> !(|(rq_ack_q | rq_nak_q)));
  a_resp_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(rq_ack_q | rq_nak_q));

endmodule

// File: tb/tb_se_lookup_arbiter.sv
// Bench for se_lookup_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a transaction-timeline model.
module tb_se_lookup_arbiter;

  localparam int TO = 12;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [3:0]   rq_req = '0;
  logic [191:0] rq_mac = '0;
  logic [39:0]  rq_hash = '0;
  logic [3:0]   rq_source = '0;
  logic [63:0]  rq_portmap = '0;
  logic [3:0]   rq_ack, rq_nak, pending, ovf_err;
  logic [15:0]  rq_result;
  logic         se_req, se_source, to_err;
  logic [47:0]  se_mac;
  logic [9:0]   se_hash;
  logic [15:0]  source_portmap;
  logic         se_ack = 1'b0;
  logic         se_nak = 1'b0;
  logic [15:0]  se_result = '0;
  logic [1:0]   dbg_state;

  se_lookup_arbiter #(.N_REQ(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .rq_req(rq_req), .rq_mac(rq_mac), .rq_hash(rq_hash),
    .rq_source(rq_source), .rq_portmap(rq_portmap), .rq_ack(rq_ack), .rq_nak(rq_nak),
    .rq_result(rq_result), .se_req(se_req), .se_mac(se_mac), .se_hash(se_hash),
    .se_source(se_source), .source_portmap(source_portmap), .se_ack(se_ack),
    .se_nak(se_nak), .se_result(se_result), .pending(pending), .ovf_err(ovf_err),
    .to_err(to_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  // Reference model: pending slots plus a timeline of the single in-flight lookup.
  logic [3:0]  m_pend = '0;
  logic [47:0] m_mac [4];
  logic [9:0]  m_hash [4];
  logic        m_src [4];
  logic [15:0] m_pm [4];
  int          m_last = 3;
  bit          m_busy = 0;
  int          m_w = 0;
  int          m_kind = 0;   // 0 ack, 1 nak, 2 ack+nak, 3 silent
  longint      m_issue = 0, m_resp = 0, m_eng_at = -1;
  logic [15:0] m_val = '0;
  logic [3:0]  m_ovf = '0;
  bit          m_to = 0;

  // Stimulus controls.
  logic [3:0]  s_req = '0;
  logic [47:0] d_mac [4];
  logic [9:0]  d_hash [4];
  logic        d_src [4];
  logic [15:0] d_pm [4];
  bit          rand_data = 0, plan_random = 0, stray_en = 0, stray_all = 0;
  int          plan_kind = 0, plan_delay = 2;
  logic [15:0] plan_val = '0;

  // Observed completions.
  int          ack_log[$];
  logic [1:0]  exp_q[$];
  longint      last_se_cyc = -1, last_resp_cyc = -1;
  logic        last_resp_ack = 1'b0;
  logic [15:0] last_resp_res = '0;
  int          last_resp_idx = -1;

  typedef struct {
    int          id;
    logic [47:0] mac;
    logic [9:0]  hash;
    logic        src;
    logic [15:0] pm;
    int          kind;
    int          delay;
    logic [15:0] eng_val;
    logic        exp_ack;
    logic [15:0] exp_res;
    int          exp_lat;
  } vec_t;
  vec_t vec [5];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic budget_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d got=expired want=done", name, cyc);
  endtask

  // One clock cycle: compare, drive, advance model, move to next cycle.
  task automatic step();
    logic [3:0] exp_a, exp_n, rel, acc, pcur;
    bit in_resp, found;
    int r, dly, c;
    in_resp = m_busy && (cyc == m_resp);
    exp_a = '0;
    exp_n = '0;
    if (in_resp) begin
      if (m_kind == 1 || m_kind == 3) exp_n[m_w] = 1'b1;
      else exp_a[m_w] = 1'b1;
    end
    chk("se_req", se_req, m_busy && (cyc == m_issue));
    chk("rq_ack", rq_ack, exp_a);
    chk("rq_nak", rq_nak, exp_n);
    if (in_resp) chk("rq_result", rq_result, (m_kind == 3) ? 16'h0 : m_val);
    if (m_busy && cyc >= m_issue && cyc < m_resp)
      chk("se_operands", {se_mac, se_hash, se_source, source_portmap},
          {m_mac[m_w], m_hash[m_w], m_src[m_w], m_pm[m_w]});
    chk("pending", pending, m_pend);
    chk("ovf_err", ovf_err, m_ovf);
    chk("to_err", to_err, m_to);

    if (se_req) last_se_cyc = cyc;
    if ((rq_ack | rq_nak) != 4'b0) begin
      last_resp_cyc = cyc;
      last_resp_ack = |rq_ack;
      last_resp_res = rq_result;
      for (int i = 0; i < 4; i++)
        if (rq_ack[i] | rq_nak[i]) begin
          last_resp_idx = i;
          ack_log.push_back(i);
        end
    end

    for (int i = 0; i < 4; i++) begin
      if (rand_data) begin
        d_mac[i]  = 48'({$urandom, $urandom});
        d_hash[i] = 10'($urandom);
        d_src[i]  = 1'($urandom);
        d_pm[i]   = 16'($urandom);
      end
      rq_mac[48*i +: 48]     = d_mac[i];
      rq_hash[10*i +: 10]    = d_hash[i];
      rq_source[i]           = d_src[i];
      rq_portmap[16*i +: 16] = d_pm[i];
    end
    rq_req    = s_req;
    se_ack    = 1'b0;
    se_nak    = 1'b0;
    se_result = 16'($urandom);
    if (m_busy && cyc == m_eng_at) begin
      if (!plan_random) se_result = plan_val;
      se_ack = (m_kind != 1);
      se_nak = (m_kind != 0);
      m_val  = se_result;
    end else if ((stray_all || (stray_en && $urandom_range(0, 3) == 0)) &&
                 (!m_busy || cyc == m_issue || cyc == m_resp)) begin
      se_ack = 1'($urandom_range(0, 1));
      se_nak = ~se_ack | 1'($urandom_range(0, 1));
    end

    rel  = in_resp ? (4'(1) << m_w) : 4'b0;
    pcur = m_pend;
    acc  = '0;
    for (int i = 0; i < 4; i++) begin
      if (s_req[i]) begin
        if (!pcur[i] || rel[i]) begin
          acc[i]  = 1'b1;
          m_mac[i] = d_mac[i];
          m_hash[i] = d_hash[i];
          m_src[i] = d_src[i];
          m_pm[i]  = d_pm[i];
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
    if (m_busy && m_kind == 3 && cyc + 1 == m_resp) m_to = 1;
    if (in_resp) begin
      m_last = m_w;
      m_busy = 0;
    end else if (!m_busy && pcur != 4'b0) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!found && pcur[c]) begin
          m_w = c;
          found = 1;
        end
      end
      m_busy  = 1;
      m_issue = cyc + 1;
      if (plan_random) begin
        r      = $urandom_range(0, 7);
        m_kind = (r == 0) ? 3 : (r % 3);
        dly    = $urandom_range(1, ($urandom_range(0, 3) == 0) ? TO : 4);
      end else begin
        m_kind = plan_kind;
        dly    = plan_delay;
      end
      m_eng_at = (m_kind == 3) ? -1 : m_issue + dly;
      m_resp   = (m_kind == 3) ? m_issue + TO + 1 : m_issue + dly + 1;
    end
    m_pend = (pcur & ~rel) | acc;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    s_req = '0;
    while ((m_busy || m_pend != 4'b0) && k < 300) begin
      step();
      k++;
    end
    if (m_busy || m_pend != 4'b0) budget_fail("idle_budget");
  endtask

  task automatic wait_acks(input int n);
    int k;
    k = 0;
    while (ack_log.size() < n && k < 400) begin
      step();
      k++;
    end
    if (ack_log.size() < n) budget_fail("ack_budget");
  endtask

  task automatic check_order(input string name);
    while (exp_q.size() > 0) begin
      if (ack_log.size() == 0) chk(name, 80'hf, exp_q.pop_front());
      else chk(name, ack_log.pop_front(), exp_q.pop_front());
    end
  endtask

  // Requests pulsed while reset is low must be lost.
  task automatic do_reset();
    rstn   = 1'b0;
    rq_req = 4'hf;
    se_ack = 1'b1;
    se_nak = 1'b0;
    #1;
    chk("rst_ack", rq_ack, 0);
    chk("rst_nak", rq_nak, 0);
    chk("rst_pending", pending, 0);
    chk("rst_se_req", se_req, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_errs", {ovf_err, to_err}, 0);
    chk("rst_operands", {se_mac, se_hash, se_source, source_portmap}, 0);
    repeat (2) @(posedge clk);
    #1;
    rq_req = '0;
    se_ack = 1'b0;
    rstn   = 1'b1;
    m_pend = '0;
    m_busy = 0;
    m_last = 3;
    m_ovf  = '0;
    m_to   = 0;
    s_req  = '0;
    cyc   += 2;
  endtask

  initial begin
    int n0, n1;
    for (int i = 0; i < 4; i++) begin
      d_mac[i] = 48'h0; d_hash[i] = 10'h0; d_src[i] = 1'b0; d_pm[i] = 16'h0;
      m_mac[i] = 48'h0; m_hash[i] = 10'h0; m_src[i] = 1'b0; m_pm[i] = 16'h0;
    end
    do_reset();

    vec[0] = '{2, 48'h0011_2233_4455, 10'h155, 1'b0, 16'h00f0, 0, 3, 16'h0003, 1'b1, 16'h0003, 6};
    vec[1] = '{0, 48'hA1B2_C3D4_E5F6, 10'h2AA, 1'b1, 16'h8001, 1, 1, 16'hBEEF, 1'b0, 16'hBEEF, 4};
    vec[2] = '{3, 48'hFFFF_0000_FFFF, 10'h3FF, 1'b1, 16'hFFFF, 2, 2, 16'h1234, 1'b1, 16'h1234, 5};
    vec[3] = '{1, 48'h0000_0000_0001, 10'h001, 1'b0, 16'h0002, 0, TO, 16'h0A0A, 1'b1, 16'h0A0A, TO + 3};
    vec[4] = '{1, 48'h1234_5678_9ABC, 10'h0F0, 1'b1, 16'h5A5A, 3, 0, 16'hDEAD, 1'b0, 16'h0000, TO + 3};
    stray_en = 1;
    for (int v = 0; v < 5; v++) begin
      longint t0;
      int k;
      wait_idle();
      plan_kind  = vec[v].kind;
      plan_delay = vec[v].delay;
      plan_val   = vec[v].eng_val;
      d_mac[vec[v].id]  = vec[v].mac;
      d_hash[vec[v].id] = vec[v].hash;
      d_src[vec[v].id]  = vec[v].src;
      d_pm[vec[v].id]   = vec[v].pm;
      last_se_cyc   = -1;
      last_resp_cyc = -1;
      t0 = cyc;
      s_req = 4'(1) << vec[v].id;
      step();
      s_req = '0;
      k = 0;
      while (last_resp_cyc < 0 && k < TO + 10) begin
        step();
        k++;
      end
      chk("vec_se_req_lat", 80'(last_se_cyc - t0), 2);
      chk("vec_resp_lat", 80'(last_resp_cyc - t0), 80'(vec[v].exp_lat));
      chk("vec_ack_kind", last_resp_ack, vec[v].exp_ack);
      chk("vec_result", last_resp_res, vec[v].exp_res);
      chk("vec_who", 80'(last_resp_idx), 80'(vec[v].id));
    end
    wait_idle();
    stray_all = 1;
    repeat (6) step();
    stray_all = 0;
    stray_en  = 0;
    chk("to_err_sticky", to_err, 1);

    // Contention after reset: one grant each, in order 0..3.
    do_reset();
    ack_log.delete();
    plan_kind = 0; plan_delay = 2;
    s_req = 4'hf;
    step();
    s_req = '0;
    wait_acks(4);
    for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
    check_order("contention_order");
    wait_idle();

    // Fairness: 0 re-requests on each of its acks while 1 stays pending.
    do_reset();
    ack_log.delete();
    n0 = 0; n1 = 0;
    s_req = 4'b0011;
    step();
    for (int k = 0; k < 300 && ack_log.size() < 4; k++) begin
      s_req = '0;
      if (m_busy && cyc == m_resp) begin
        if (m_w == 0 && n0 < 2) begin s_req[0] = 1'b1; n0++; end
        if (m_w == 1 && n1 < 1) begin s_req[1] = 1'b1; n1++; end
      end
      step();
    end
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    check_order("fairness_order");
    wait_idle();
    ack_log.delete();

    // Overflow: second pulse of requester 1 lands while its lookup is in WAIT.
    do_reset();
    plan_kind = 0; plan_delay = 10;
    s_req = 4'b0010;
    step();
    s_req = '0;
    repeat (5) step();
    s_req = 4'b0010;
    step();
    s_req = '0;
    wait_idle();
    repeat (3) step();
    chk("ovf_flag", ovf_err, 4'b0010);
    chk("ovf_single_ack", 80'(ack_log.size()), 1);
    ack_log.delete();

    // Reset mid-WAIT aborts silently; requester 0 wins first afterwards.
    do_reset();
    plan_kind = 0; plan_delay = 2;
    s_req = 4'b0001;
    step();
    wait_idle();
    plan_kind = 3;
    s_req = 4'b0010;
    step();
    s_req = '0;
    repeat (4) step();
    chk("midwait_state", dbg_state, 2'd2);
    ack_log.delete();
    do_reset();
    plan_kind = 0; plan_delay = 2;
    repeat (4) step();
    chk("midwait_no_resp", 80'(ack_log.size()), 0);
    s_req = 4'hf;
    step();
    s_req = '0;
    wait_acks(4);
    for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
    check_order("post_reset_order");
    wait_idle();

    // Random traffic with random engine behaviour and stray engine pulses.
    do_reset();
    rand_data = 1; plan_random = 1; stray_en = 1;
    for (int k = 0; k < 2500; k++) begin
      for (int i = 0; i < 4; i++) s_req[i] = ($urandom_range(0, 9) == 0);
      step();
    end
    wait_idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/se_lookup_arbiter.md
SE_LOOKUP_ARBITER -- requirements
Module: se_lookup_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of frame-processor requesters (fixed 4 in this revision).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before forced nak.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 rq_req  in  4  per-requester single-cycle lookup request pulse.
REQ-006 rq_mac  in  192  per-requester MAC; requester i on bits [48i+47:48i].
REQ-007 rq_hash  in  40  per-requester hash; requester i on bits [10i+9:10i].
REQ-008 rq_source  in  4  per-requester flag: 1 = source-learn lookup, 0 = destination lookup.
REQ-009 rq_portmap  in  64  per-requester source portmap; requester i on bits [16i+15:16i].
REQ-010 rq_ack / rq_nak  out  4 each  per-requester one-cycle completion pulses.
REQ-011 rq_result  out  16  lookup result; valid only in the rq_ack/rq_nak cycle.
REQ-012 se_req  out  1  one-cycle request to the search engine.
REQ-013 se_mac 48, se_hash 10, se_source 1, source_portmap 16  out  registered engine operands.
REQ-014 se_ack, se_nak  in  1 each  engine completion; se_result  in  16.
REQ-015 pending  out  4  per-requester pending status; ovf_err  out  4  sticky per-requester drop flag; to_err  out  1  sticky timeout flag.

Function
REQ-016 SHALL hold one capture slot per requester: rq_req[i]=1 latches mac/hash/source/portmap of i and sets pending[i] at the next edge.
REQ-017 If rq_req[i]=1 while pending[i]=1 and slot i is not being released that cycle, the request SHALL be dropped, the slot unchanged, ovf_err[i] set.
REQ-018 If rq_req[i]=1 in the same cycle slot i is released (RESP for i), the new request SHALL be accepted with no error.
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-020 IDLE: when any pending bit is set, SHALL pick a winner round-robin starting at (last_grant+1) mod 4, load the se_* operands from its slot, and go to ISSUE.
REQ-021 ISSUE: se_req=1 for exactly this one cycle; operands stable from ISSUE until leaving WAIT; next state WAIT.
REQ-022 WAIT: timer counts from 1 each cycle; se_ack -> RESP(ack); else se_nak -> RESP(nak); else timer==TIMEOUT -> RESP(nak) and set to_err.
REQ-023 se_ack and se_nak in the same cycle SHALL be treated as ack.
REQ-024 se_ack/se_nak outside WAIT SHALL be ignored.
REQ-025 RESP: pulse rq_ack[w] or rq_nak[w] for one cycle; rq_result = captured se_result (0 on timeout); clear pending[w]; last_grant <= w; next state IDLE.
REQ-026 Latency: rq_req at cycle t with arbiter idle and no other pending -> se_req at t+2; se_ack at cycle a -> rq_ack at a+1.
REQ-027 Requests arriving during a transaction SHALL wait; no requester SHALL be skipped more than 3 consecutive grants.
REQ-028 rq_ack, rq_nak, se_req SHALL never be asserted in two consecutive cycles.

Reset
REQ-029 rstn low SHALL immediately force IDLE, clear pending, slots, timer, ovf_err, to_err, all outputs to 0 and last_grant to 3, so that requester 0 is granted first.
REQ-030 Reset mid-transaction SHALL abort it with no ack/nak issued; requests pulsed during reset SHALL be lost.

Verification
REQ-031 Single: rq_req[2] at t, mac=0x0011_2233_4455, hash=0x155, engine acks at t+5 with 0x0003 -> se_req at t+2 with those operands, rq_ack[2] at t+6, rq_result=0x0003, pending=0.
REQ-032 Contention: rq_req=4'b1111 at one cycle after reset -> grants in order 0,1,2,3, each a separate se_req, one rq_ack per requester.
REQ-033 Fairness: requester 0 re-requests immediately after each ack while 1 stays pending -> grant order 0,1,0,1.
REQ-034 Overflow: requester 1 pulses at cycles t and t+6 while its first lookup is unacked -> second dropped, ovf_err=4'b0010, one rq_ack[1] only.
REQ-035 Timeout: engine silent after se_req -> rq_nak[w] exactly TIMEOUT+1 cycles after se_req, rq_result=0, to_err=1; late se_ack afterwards ignored.
REQ-036 Reset mid-WAIT: rstn low during WAIT -> no rq_ack/rq_nak, pending=0, next request granted to requester 0 first.
